// File: rtl/demux4_reg.sv
// 1-to-4 registered demultiplexer with one-word holding register per channel,
// select-driven or round-robin routing, and per-channel valid/ready handshakes.
module demux4_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         mode,
  input  logic [1:0]   s,
  input  logic [W-1:0] d,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] o0,
  output logic [W-1:0] o1,
  output logic [W-1:0] o2,
  output logic [W-1:0] o3,
  output logic [3:0]   o_valid,
  input  logic [3:0]   o_ready,
  output logic [1:0]   rr_ptr
);

  logic [W-1:0] data_q [4];
  logic [W-1:0] data_d [4];
  logic [3:0]   vld_q, vld_d;
  logic [1:0]   rr_q, rr_d;
  logic [1:0]   tgt;
  logic         accept;

  always_comb begin
    tgt      = mode ? rr_q : s;
    in_ready = ~vld_q[tgt] | o_ready[tgt];
    accept   = in_valid & in_ready;

    data_d = data_q;
    rr_d   = rr_q;
    // Drains clear first; a load on the same channel then re-sets its valid.
    vld_d  = vld_q & ~o_ready;
    if (accept) begin
      data_d[tgt] = d;
      vld_d[tgt]  = 1'b1;
      if (mode) begin
        rr_d = rr_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int unsigned i = 0; i < 4; i++) begin
        data_q[i] <= '0;
      end
      vld_q <= '0;
      rr_q  <= '0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
      rr_q   <= rr_d;
    end
  end

  assign o0      = data_q[0];
  assign o1      = data_q[1];
  assign o2      = data_q[2];
  assign o3      = data_q[3];
  assign o_valid = vld_q;
  assign rr_ptr  = rr_q;

endmodule

// File: tb/tb_demux4_reg.sv
// Directed and randomized checks of demux4_reg routing, backpressure,
// round-robin advance and asynchronous reset.
module tb_demux4_reg;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_b;
  logic         mode;
  logic [1:0]   s;
  logic [W-1:0] d;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] o0, o1, o2, o3;
  logic [3:0]   o_valid;
  logic [3:0]   o_ready;
  logic [1:0]   rr_ptr;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  demux4_reg #(.W(W)) dut (
    .clk(clk), .rst_b(rst_b), .mode(mode), .s(s), .d(d),
    .in_valid(in_valid), .in_ready(in_ready),
    .o0(o0), .o1(o1), .o2(o2), .o3(o3),
    .o_valid(o_valid), .o_ready(o_ready), .rr_ptr(rr_ptr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] out_of(input int unsigned i);
    case (i)
      0:       return o0;
      1:       return o1;
      2:       return o2;
      default: return o3;
    endcase
  endfunction

  // advance one clock; inputs may be changed right after this returns
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] sb [4][$];
  logic [3:0]   m_vld;
  logic [1:0]   m_rr;
  logic [1:0]   m_tgt;
  logic         m_rdy;
  logic [W-1:0] exp_w;

  initial begin
    rst_b = 1'b0; mode = 1'b0; s = 2'd0; d = '0; in_valid = 1'b0; o_ready = 4'h0;
    #12;
    check("rst_o_valid", 32'(o_valid), 32'h0);
    check("rst_o0", 32'(o0), 32'h0);
    check("rst_o3", 32'(o3), 32'h0);
    check("rst_rr", 32'(rr_ptr), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    rst_b = 1'b1;
    tick();
    check("post_rst_in_ready", 32'(in_ready), 32'h1);

    // single word routed to channel 2
    s = 2'd2; d = 8'hA5; in_valid = 1'b1;
    #1 check("sel_in_ready", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    check("sel_o2", 32'(o2), 32'hA5);
    check("sel_o_valid", 32'(o_valid), 32'h4);
    check("sel_o0", 32'(o0), 32'h0);
    check("sel_o1", 32'(o1), 32'h0);
    check("sel_o3", 32'(o3), 32'h0);

    // backpressure on full channel 2, then simultaneous drain and load
    d = 8'h3C; in_valid = 1'b1;
    #1 check("bp_in_ready", 32'(in_ready), 32'h0);
    tick();
    check("bp_o2_hold", 32'(o2), 32'hA5);
    check("bp_o_valid_hold", 32'(o_valid), 32'h4);
    o_ready = 4'b0100;
    #1 check("bp_in_ready_drain", 32'(in_ready), 32'h1);
    tick();
    check("bp_o2_new", 32'(o2), 32'h3C);
    check("bp_o_valid_new", 32'(o_valid), 32'h4);
    in_valid = 1'b0;
    tick();
    check("drain_o_valid", 32'(o_valid), 32'h0);
    check("drain_o2_keep", 32'(o2), 32'h3C);
    o_ready = 4'h0;

    // accept on channel 1 while channel 3 drains
    s = 2'd3; d = 8'h77; in_valid = 1'b1;
    tick();
    check("ch3_o_valid", 32'(o_valid), 32'h8);
    s = 2'd1; d = 8'h55; o_ready = 4'b1000;
    tick();
    check("x_o_valid", 32'(o_valid), 32'h2);
    check("x_o1", 32'(o1), 32'h55);
    check("x_o3_keep", 32'(o3), 32'h77);
    in_valid = 1'b0; o_ready = 4'b0010;
    tick();
    check("x_drain", 32'(o_valid), 32'h0);

    // round-robin with all consumers ready
    mode = 1'b1; o_ready = 4'hF; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      d = 8'(8'h10 + k);
      #1 check("rr_ptr_seq", 32'(rr_ptr), 32'(k % 4));
      tick();
      check("rr_data", 32'(out_of(k % 4)), 32'(8'h10 + k));
      check("rr_o_valid", 32'(o_valid), 32'(4'b0001 << (k % 4)));
    end
    in_valid = 1'b0;
    #1 check("rr_ptr_end", 32'(rr_ptr), 32'h1);
    tick();
    check("rr_no_accept_ptr", 32'(rr_ptr), 32'h1);
    check("rr_drained", 32'(o_valid), 32'h0);

    // mode 0 leaves rr_ptr alone; fill two channels then async reset
    mode = 1'b0; o_ready = 4'h0; in_valid = 1'b1; s = 2'd0; d = 8'h11;
    tick();
    s = 2'd2; d = 8'h22;
    tick();
    in_valid = 1'b0;
    check("m0_rr_keep", 32'(rr_ptr), 32'h1);
    check("two_full", 32'(o_valid), 32'h5);
    mode = 1'b1;
    #1 check("mode_switch_ready", 32'(in_ready), 32'h1);
    mode = 1'b0;
    #1 rst_b = 1'b0;
    #1;
    check("arst_o_valid", 32'(o_valid), 32'h0);
    check("arst_o0", 32'(o0), 32'h0);
    check("arst_o2", 32'(o2), 32'h0);
    check("arst_rr", 32'(rr_ptr), 32'h0);
    check("arst_in_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    rst_b = 1'b1;
    tick();

    // random traffic against a scoreboard
    m_vld = 4'h0; m_rr = 2'd0;
    for (int c = 0; c < 1000; c++) begin
      mode     = 1'($urandom_range(0, 1));
      s        = 2'($urandom_range(0, 3));
      d        = 8'($urandom_range(0, 255));
      in_valid = 1'($urandom_range(0, 1));
      o_ready  = 4'($urandom_range(0, 15));
      #1;
      m_tgt = mode ? m_rr : s;
      m_rdy = ~m_vld[m_tgt] | o_ready[m_tgt];
      check("rnd_in_ready", 32'(in_ready), 32'(m_rdy));
      check("rnd_o_valid", 32'(o_valid), 32'(m_vld));
      check("rnd_rr", 32'(rr_ptr), 32'(m_rr));
      for (int i = 0; i < 4; i++) begin
        if (m_vld[i] && o_ready[i]) begin
          if (sb[i].size() == 0) begin
            check("rnd_sb_underflow", 32'(i), 32'hFFFF);
          end else begin
            exp_w = sb[i].pop_front();
            check("rnd_data", 32'(out_of(i)), 32'(exp_w));
          end
        end
      end
      m_vld = m_vld & ~o_ready;
      if (in_valid && m_rdy) begin
        sb[m_tgt].push_back(d);
        m_vld[m_tgt] = 1'b1;
        if (mode) m_rr = m_rr + 2'd1;
      end
      tick();
    end
    in_valid = 1'b0; o_ready = 4'h0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("rnd_final_count", 32'(sb[i].size()), 32'(m_vld[i]));
      if (m_vld[i]) check("rnd_final_data", 32'(out_of(i)), 32'(sb[i][0]));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
